// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per op over a req/ack bus, with byte enables, lane steering and load extension.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word ops complete immediately with err instead of being aligned down.
module load_store_unit #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic              op_write,
  input  logic [1:0]        op_size,
  input  logic              op_unsigned,
  input  logic [31:0]       op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [31:0]       ld_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          off_q, off_d;
  logic                uns_q, uns_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [31:0]         ld_data_q, ld_data_d;

  logic [1:0]          a_eff;
  logic [3:0]          be_new;
  logic [31:0]         wdata_new;
  logic                trap;
  logic                timed_out;
  logic                unused_addr_hi;

  // Upper address bits wrap away.
  assign unused_addr_hi = ^op_addr[31:ADDR_W+2];

  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   extract_load = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   extract_load = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: extract_load = rdata;
    endcase
  endfunction

  // Lane offset after aligning down; misaligned ops only reach the bus when not trapped.
  always_comb begin
    case (op_size)
      2'b00: begin
        a_eff     = op_addr[1:0];
        be_new    = 4'b0001 << op_addr[1:0];
        wdata_new = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        a_eff     = {op_addr[1], 1'b0};
        be_new    = op_addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{op_wdata[15:0]}};
      end
      default: begin
        a_eff     = 2'b00;
        be_new    = 4'b1111;
        wdata_new = op_wdata;
      end
    endcase
`ifdef MISALIGN_TRAP_EN
    trap = ((op_size == 2'b01) && op_addr[0]) ||
           (op_size[1] && (op_addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  assign timed_out = (TIMEOUT_CYC != 0) &&
                     (({1'b0, cnt_q} + 1'b1) == (CNT_W + 1)'(TIMEOUT_CYC));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ld_data_d   = 32'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          size_d      = op_size;
          off_d       = a_eff;
          uns_d       = op_unsigned;
          mem_we_d    = op_write;
          mem_addr_d  = op_addr[ADDR_W+1:2];
          mem_be_d    = be_new;
          mem_wdata_d = wdata_new;
          cnt_d       = '0;
          if (trap) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = S_REQ;
            mem_req_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          cnt_d     = '0;
          ld_data_d = mem_we_q ? 32'b0 : extract_load(mem_rdata, size_q, off_q, uns_q);
        end else if (timed_out) begin
          state_d   = S_DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0;
      mem_wdata_q <= 32'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ld_data_q   <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ld_data_q   <= ld_data_d;
    end
  end

  // Gated by reset so stall also reads 0 while reset is held.
  assign stall     = reset && (((state_q == S_IDLE) && op_valid) || (state_q == S_REQ));
  assign done      = done_q;
  assign err       = err_q;
  assign ld_data   = ld_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a behavioural model of the memory op rules.
module tb_load_store_unit;

  localparam int ADDR_W = 10;
  localparam int TO     = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              op_valid, op_write, op_unsigned;
  logic [1:0]        op_size;
  logic [31:0]       op_addr, op_wdata;
  logic              stall, done, err;
  logic [31:0]       ld_data;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_write(op_write), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .stall(stall), .done(done), .err(err), .ld_data(ld_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] model_ld(input logic [1:0] sz, input logic uns,
                                           input logic [1:0] ae, input logic [31:0] rd);
    int v;
    logic [7:0]  b;
    logic [15:0] h;
    if (sz == 2'd0) begin
      b = rd[8*ae +: 8];
      v = int'(b);
      if (!uns && b[7]) v = v - 256;
      return 32'(v);
    end else if (sz == 2'd1) begin
      h = rd[16*ae[1] +: 16];
      v = int'(h);
      if (!uns && h[15]) v = v - 65536;
      return 32'(v);
    end
    return rd;
  endfunction

  // ack_dly < 0 means the responder never acks.
  task automatic run_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] rd, input string tag);
    logic [1:0]        a, ae;
    logic              mis, trap, tmo, exp_err, bad_stall;
    logic [3:0]        exp_be;
    logic [31:0]       exp_wd, exp_ld;
    logic [ADDR_W-1:0] exp_addr;
    int                exp_cyc, cyc;
    a   = addr[1:0];
    mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a != 2'd0);
`ifdef MISALIGN_TRAP_EN
    trap = mis;
`else
    trap = 1'b0;
`endif
    ae = a;
    if (sz == 2'd1) ae[0] = 1'b0;
    else if (sz >= 2'd2) ae = 2'd0;
    exp_wd = wd;
    if (sz == 2'd0) begin
      exp_be = 4'b0001 << ae;
      for (int l = 0; l < 4; l++) exp_wd[8*l +: 8] = wd[7:0];
    end else if (sz == 2'd1) begin
      exp_be = ae[1] ? 4'b1100 : 4'b0011;
      exp_wd = {wd[15:0], wd[15:0]};
    end else begin
      exp_be = 4'b1111;
    end
    exp_addr = addr[ADDR_W+1:2];
    tmo      = (ack_dly < 0);
    exp_cyc  = trap ? 0 : (tmo ? TO : ack_dly + 1);
    exp_err  = trap || tmo;
    exp_ld   = (exp_err || wr) ? 32'd0 : model_ld(sz, uns, ae, rd);

    @(negedge clk);
    op_valid = 1'b1; op_write = wr; op_size = sz; op_unsigned = uns;
    op_addr = addr; op_wdata = wd;
    #1;
    n_vec++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL %s stall_accept got %b want 1", tag, stall);
    end
    @(negedge clk);
    op_valid = 1'b0; op_write = $urandom; op_size = $urandom; op_unsigned = $urandom;
    op_addr = $urandom; op_wdata = $urandom;
    if (!trap) begin
      n_vec++;
      if (mem_we !== wr || mem_addr !== exp_addr || mem_be !== exp_be || mem_wdata !== exp_wd) begin
        n_fail++;
        $display("FAIL %s bus got we=%b addr=%h be=%b wd=%h want we=%b addr=%h be=%b wd=%h",
                 tag, mem_we, mem_addr, mem_be, mem_wdata, wr, exp_addr, exp_be, exp_wd);
      end
    end
    cyc = 0;
    bad_stall = 1'b0;
    while (mem_req === 1'b1 && cyc < 40) begin
      if (stall !== 1'b1 || done !== 1'b0) bad_stall = 1'b1;
      mem_ack   = (cyc == ack_dly);
      mem_rdata = (cyc == ack_dly) ? rd : $urandom;
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    n_vec++;
    if (bad_stall) begin
      n_fail++; $display("FAIL %s stall_or_done_during_req", tag);
    end
    n_vec++;
    if (cyc != exp_cyc) begin
      n_fail++; $display("FAIL %s req_cycles got %0d want %0d", tag, cyc, exp_cyc);
    end
    n_vec++;
    if (done !== 1'b1 || err !== exp_err || ld_data !== exp_ld || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL %s completion got done=%b err=%b ld=%h stall=%b want done=1 err=%b ld=%h stall=0",
               tag, done, err, ld_data, stall, exp_err, exp_ld);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done got done=%b req=%b want 0 0", tag, done, mem_req);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; op_valid = 1'b0; op_write = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
    op_addr = 32'd0; op_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({stall, done, err, ld_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got stall=%b done=%b err=%b ld=%h req=%b we=%b addr=%h be=%b wd=%h want all 0",
               stall, done, err, ld_data, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_op(1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_00AB, 3, 32'h0, "store_byte");
    run_op(1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'h0, 1, 32'h8001_1234, "load_half_signed");
    run_op(1'b0, 2'd1, 1'b1, 32'h0000_000A, 32'h0, 0, 32'h8001_1234, "load_half_unsigned");
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF, "load_word_fast");
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_0003, 32'h0, 2, 32'h80FF_7F01, "load_byte_lane3");
    run_op(1'b0, 2'd3, 1'b1, 32'hFFFF_F00C, 32'h0, 1, 32'h1234_5678, "size3_addr_wrap");
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 0, 32'hCAFE_F00D, "misaligned_word");
    run_op(1'b1, 2'd1, 1'b0, 32'h0000_0105, 32'h1111_BEEF, 0, 32'h0, "misaligned_half_store");
  endtask

  task automatic test_timeout;
    run_op(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, -1, 32'h0, "timeout_load");
    run_op(1'b1, 2'd2, 1'b0, 32'h0000_0024, 32'h5555_AAAA, 0, 32'h0, "after_timeout");
  endtask

  task automatic test_stray_ack;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL stray_ack got done=%b req=%b err=%b want 0 0 0", done, mem_req, err);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid_req;
    @(negedge clk);
    op_valid = 1'b1; op_write = 1'b0; op_size = 2'd2; op_addr = 32'h40; op_unsigned = 1'b0;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || mem_be !== 4'b0) begin
      n_fail++; $display("FAIL reset_mid_req got req=%b stall=%b done=%b be=%b want 0 0 0 0",
                         mem_req, stall, done, mem_be);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(1'b0, 2'd0, 1'b0, 32'h0000_0041, 32'h0, 1, 32'h0000_F200, "after_reset");
  endtask

  task automatic test_random;
    logic [1:0] sz;
    int         dly;
    for (int i = 0; i < 60; i++) begin
      sz  = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      run_op(1'($urandom), sz, 1'($urandom), $urandom, $urandom, dly, $urandom, "random");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_timeout;
    test_stray_ack;
    test_reset_mid_req;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
